// File: rtl/s_flag_sequencer_if.sv
// Request/result handshake bundle for the s_flag sequencer.
// master drives requests and the result-ready, slave is the sequencer.
interface s_flag_sequencer_if #(
  parameter int WIDTH = 128
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [2:0]       opsel;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic             s_flag;
  logic             lt;
  logic             busy;

  modport master (
    output in_valid, op1, op2, opsel, mode, out_ready,
    input  in_ready, out_valid, s_flag, lt, busy
  );

  modport slave (
    input  in_valid, op1, op2, opsel, mode, out_ready,
    output in_ready, out_valid, s_flag, lt, busy
  );
endinterface

// File: rtl/s_flag_sequencer.sv
// Multi-cycle sign/compare flag generator: MSB-first chunked unsigned compare
// with early exit, one request in flight, valid/ready on both sides.
//
// state     | meaning
// S_IDLE    | ready for a request; flags hold the last result
// S_COMPARE | scanning chunk idx_q of the captured operands, MSB chunk first
// S_DONE    | result presented on out_valid until the consumer takes it
module s_flag_sequencer #(
  parameter int WIDTH = 128,
  parameter int CHUNK = 32
) (
  input logic                clk,
  input logic                rst,
  s_flag_sequencer_if.slave  bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic             need_cmp_q, need_cmp_d;
  logic             lt_q, lt_d;
  logic             s_flag_q, s_flag_d;

  logic             need_cmp_in;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic             unused_opsel;

  // opsel[1] does not take part in flag selection
  assign unused_opsel = bus.opsel[1];
  assign need_cmp_in  = !bus.mode & !bus.opsel[2] & bus.opsel[0];

  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_chunk = op1_q[i*CHUNK +: CHUNK];
        b_chunk = op2_q[i*CHUNK +: CHUNK];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    need_cmp_d = need_cmp_q;
    lt_d       = lt_q;
    s_flag_d   = s_flag_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op1_d      = bus.op1;
          op2_d      = bus.op2;
          need_cmp_d = need_cmp_in;
          lt_d       = 1'b0;
          s_flag_d   = 1'b0;
          if (need_cmp_in) begin
            state_d = S_COMPARE;
            idx_d   = IDX_LAST;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_COMPARE: begin
        // the first differing chunk from the top decides the whole compare
        if (a_chunk != b_chunk) begin
          lt_d     = (a_chunk < b_chunk);
          s_flag_d = need_cmp_q & (a_chunk < b_chunk);
          state_d  = S_DONE;
        end else if (idx_q == '0) begin
          lt_d     = 1'b0;
          s_flag_d = 1'b0;
          state_d  = S_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      need_cmp_q <= 1'b0;
      lt_q       <= 1'b0;
      s_flag_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      need_cmp_q <= need_cmp_d;
      lt_q       <= lt_d;
      s_flag_q   <= s_flag_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.lt        = lt_q;
  assign bus.s_flag    = s_flag_q;
endmodule
